// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run-control sequencer.
//   state_t        : run-control state encoding (HALT/RUN/STEP/BRK)
//   CNT_W          : default tick timer / period register width
//   PERIOD_DEFAULT : default period register reset value
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_BRK  = 2'd3
  } state_t;

  localparam int unsigned CNT_W          = 32;
  localparam int unsigned PERIOD_DEFAULT = 1000000;

endpackage

// File: rtl/cpu_step_ctrl_tick_timer.sv
// Tick timer: free-running counter compared against a loadable period.
// Ports:
//   i_clk, i_rst : clock, async active-high reset
//   i_enable     : count this cycle (otherwise counter held at 0)
//   i_clear      : force counter to 0, suppress expiry
//   i_load       : load i_period into period register, clear counter, suppress expiry
//   i_period     : new period value
//   o_expire     : counter equals period this cycle (combinational)
module tick_timer #(
  parameter int unsigned      CNT_W          = 32,
  parameter logic [CNT_W-1:0] PERIOD_DEFAULT = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cntr;
  logic [CNT_W-1:0] r_period;
  logic             w_match;

  assign w_match  = (r_cntr == r_period);
  assign o_expire = i_enable && !i_clear && !i_load && w_match;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cntr   <= '0;
      r_period <= PERIOD_DEFAULT;
    end else if (i_load) begin
      r_period <= i_period;
      r_cntr   <= '0;
    end else if (!i_enable || i_clear || w_match) begin
      r_cntr <= '0;
    end else begin
      r_cntr <= r_cntr + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run-control sequencer: turns hwclk into a one-cycle cpu_en strobe with
// run / halt / single-step / PC-breakpoint control.
// Ports:
//   hwclk, rst           : sole clock, async active-high reset
//   run_req/halt_req/step_req : one-cycle request pulses (halt > step > run)
//   period_load, period_in    : reload tick period (clears timer)
//   bp_en, bp_addr, pc        : breakpoint enable/address, CPU fetch address
//   cpu_en      : registered one-cycle CPU advance strobe
//   tick_led    : toggles on each cpu_en
//   state       : 0=HALT 1=RUN 2=STEP 3=BRK
//   bp_hit      : high while in BRK
//   tick_count  : number of cpu_en pulses issued (wraps)
module cpu_step_ctrl #(
  parameter int unsigned      CNT_W          = cpu_ctrl_pkg::CNT_W,
  parameter logic [CNT_W-1:0] PERIOD_DEFAULT = CNT_W'(cpu_ctrl_pkg::PERIOD_DEFAULT),
  parameter int unsigned      ADDR_W         = 32,
  parameter bit               START_RUN      = 1'b1
) (
  input  logic              hwclk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              period_load,
  input  logic [CNT_W-1:0]  period_in,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_en,
  output logic              tick_led,
  output logic [1:0]        state,
  output logic              bp_hit,
  output logic [31:0]       tick_count
);

  import cpu_ctrl_pkg::*;

  state_t      r_state;
  logic        r_cpu_en;
  logic        r_tick_led;
  logic        r_bp_hit;
  logic        r_skip_bp;
  logic [31:0] r_tick_count;

  logic w_counting;
  logic w_clear;
  logic w_expire;
  logic w_bp_match;

  assign w_counting = (r_state == ST_RUN) || (r_state == ST_STEP);
  // A halt while counting also kills any expiry landing on the same cycle.
  assign w_clear    = w_counting && halt_req;
  assign w_bp_match = bp_en && (pc == bp_addr) && !r_skip_bp;

  tick_timer #(
    .CNT_W          (CNT_W),
    .PERIOD_DEFAULT (PERIOD_DEFAULT)
  ) u_timer (
    .i_clk    (hwclk),
    .i_rst    (rst),
    .i_enable (w_counting),
    .i_clear  (w_clear),
    .i_load   (period_load),
    .i_period (period_in),
    .o_expire (w_expire)
  );

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      r_state      <= START_RUN ? ST_RUN : ST_HALT;
      r_cpu_en     <= 1'b0;
      r_tick_led   <= 1'b0;
      r_bp_hit     <= 1'b0;
      r_skip_bp    <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_cpu_en <= 1'b0;
      unique case (r_state)
        ST_HALT: begin
          if (halt_req)      r_state <= ST_HALT;
          else if (step_req) r_state <= ST_STEP;
          else if (run_req)  r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (halt_req) begin
            r_state <= ST_HALT;
          end else if (w_expire) begin
            if (w_bp_match) begin
              r_state  <= ST_BRK;
              r_bp_hit <= 1'b1;
            end else begin
              r_cpu_en     <= 1'b1;
              r_tick_led   <= ~r_tick_led;
              r_tick_count <= r_tick_count + 32'd1;
              r_skip_bp    <= 1'b0;
            end
          end
        end
        ST_STEP: begin
          if (halt_req) begin
            r_state <= ST_HALT;
          end else if (w_expire) begin
            // A run request coinciding with the step tick continues into RUN.
            r_cpu_en     <= 1'b1;
            r_tick_led   <= ~r_tick_led;
            r_tick_count <= r_tick_count + 32'd1;
            r_state      <= run_req ? ST_RUN : ST_HALT;
          end else if (run_req) begin
            r_state <= ST_RUN;
          end
        end
        ST_BRK: begin
          if (halt_req) begin
            r_state  <= ST_HALT;
            r_bp_hit <= 1'b0;
          end else if (step_req) begin
            r_state  <= ST_STEP;
            r_bp_hit <= 1'b0;
          end else if (run_req) begin
            r_state   <= ST_RUN;
            r_bp_hit  <= 1'b0;
            r_skip_bp <= 1'b1;
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  assign cpu_en     = r_cpu_en;
  assign tick_led   = r_tick_led;
  assign state      = r_state;
  assign bp_hit     = r_bp_hit;
  assign tick_count = r_tick_count;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
module tb_cpu_step_ctrl;

  logic        hwclk = 1'b0;
  logic        rst = 1'b1;
  logic        run_req = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_req = 1'b0;
  logic        period_load = 1'b0;
  logic [31:0] period_in = '0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] pc = '0;
  logic        cpu_en;
  logic        tick_led;
  logic [1:0]  state;
  logic        bp_hit;
  logic [31:0] tick_count;

  cpu_step_ctrl #(
    .CNT_W          (32),
    .PERIOD_DEFAULT (32'd3),
    .ADDR_W         (32),
    .START_RUN      (1'b1)
  ) dut (
    .hwclk       (hwclk),
    .rst         (rst),
    .run_req     (run_req),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .period_load (period_load),
    .period_in   (period_in),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .cpu_en      (cpu_en),
    .tick_led    (tick_led),
    .state       (state),
    .bp_hit      (bp_hit),
    .tick_count  (tick_count)
  );

  always #5 hwclk = ~hwclk;

  int unsigned cyc = 0;
  always @(posedge hwclk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [31:0] cnt;
    logic        led;
  } exp_t;

  exp_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_cnt  = '0;
  logic        exp_led  = 1'b0;

  localparam logic [1:0] S_HALT = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_BRK = 2'd3;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_pulse(input int unsigned c);
    exp_t e;
    exp_cnt = exp_cnt + 32'd1;
    exp_led = ~exp_led;
    e.cyc = c;
    e.cnt = exp_cnt;
    e.led = exp_led;
    q.push_back(e);
  endtask

  task automatic wait_to(input int unsigned n);
    while (cyc < n) @(negedge hwclk);
  endtask

  // Monitor: every cpu_en strobe must match the head of the scoreboard.
  always @(negedge hwclk) begin
    if (!rst && cpu_en) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: cpu_en=1 at cycle %0d, none expected", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        chk("pulse_tick_count", 64'(tick_count), 64'(e.cnt));
        chk("pulse_tick_led", 64'(tick_led), 64'(e.led));
      end
    end
  end

  initial begin
    // Reset state
    wait_to(3);
    chk("rst_cpu_en", 64'(cpu_en), 64'd0);
    chk("rst_state", 64'(state), 64'(S_RUN));
    chk("rst_tick_count", 64'(tick_count), 64'd0);
    chk("rst_tick_led", 64'(tick_led), 64'd0);
    chk("rst_bp_hit", 64'(bp_hit), 64'd0);

    // Free run, period 3: pulses every 4 cycles starting 4 after release
    for (int i = 1; i <= 5; i++) push_pulse(3 + 4 * i);
    rst = 1'b0;
    wait_to(23);
    chk("run_count5", 64'(tick_count), 64'd5);
    chk("run_led5", 64'(tick_led), 64'd1);
    wait_to(24);
    chk("run_queue_empty", 64'(q.size()), 64'd0);

    // Halt landing on an expiry cycle suppresses the tick
    wait_to(26);
    halt_req = 1'b1;
    wait_to(27);
    halt_req = 1'b0;
    chk("halt_state", 64'(state), 64'(S_HALT));
    chk("halt_no_pulse", 64'(cpu_en), 64'd0);

    // Single step from HALT: one pulse 4 cycles after entering STEP
    wait_to(30);
    step_req = 1'b1;
    push_pulse(35);
    wait_to(31);
    step_req = 1'b0;
    chk("step_state", 64'(state), 64'(S_STEP));
    wait_to(35);
    chk("step_back_halt", 64'(state), 64'(S_HALT));
    wait_to(45);
    chk("step_queue_empty", 64'(q.size()), 64'd0);

    // Breakpoint in RUN
    bp_en = 1'b1;
    bp_addr = 32'h10;
    pc = 32'h10;
    run_req = 1'b1;
    wait_to(46);
    run_req = 1'b0;
    wait_to(50);
    chk("bp_state", 64'(state), 64'(S_BRK));
    chk("bp_hit", 64'(bp_hit), 64'd1);
    wait_to(55);
    chk("bp_hold", 64'(state), 64'(S_BRK));
    run_req = 1'b1;
    push_pulse(60);
    wait_to(56);
    run_req = 1'b0;
    chk("bp_resume_state", 64'(state), 64'(S_RUN));
    chk("bp_resume_hit", 64'(bp_hit), 64'd0);
    wait_to(64);
    chk("bp_again_state", 64'(state), 64'(S_BRK));
    chk("bp_again_hit", 64'(bp_hit), 64'd1);

    // Halt from BRK, then request priority in HALT
    wait_to(66);
    halt_req = 1'b1;
    wait_to(67);
    halt_req = 1'b0;
    chk("brk_halt_state", 64'(state), 64'(S_HALT));
    chk("brk_halt_hit", 64'(bp_hit), 64'd0);
    wait_to(70);
    halt_req = 1'b1;
    step_req = 1'b1;
    run_req = 1'b1;
    wait_to(71);
    {halt_req, step_req, run_req} = 3'b000;
    chk("prio_all_halt", 64'(state), 64'(S_HALT));
    wait_to(73);
    step_req = 1'b1;
    run_req = 1'b1;
    push_pulse(78);
    wait_to(74);
    {step_req, run_req} = 2'b00;
    chk("prio_step_run", 64'(state), 64'(S_STEP));
    wait_to(78);
    chk("prio_step_done", 64'(state), 64'(S_HALT));
    wait_to(80);
    chk("prio_queue_empty", 64'(q.size()), 64'd0);

    // Period reload: 0 -> every cycle, 7 -> every 8 cycles
    bp_en = 1'b0;
    run_req = 1'b1;
    wait_to(81);
    run_req = 1'b0;
    wait_to(82);
    period_load = 1'b1;
    period_in = 32'd0;
    for (int c = 84; c <= 91; c++) push_pulse(c);
    push_pulse(100);
    push_pulse(108);
    push_pulse(116);
    wait_to(83);
    period_load = 1'b0;
    wait_to(91);
    period_load = 1'b1;
    period_in = 32'd7;
    wait_to(92);
    period_load = 1'b0;

    // Reset asserted while cpu_en is high
    wait_to(116);
    #1 rst = 1'b1;
    #1;
    chk("arst_cpu_en", 64'(cpu_en), 64'd0);
    chk("arst_count", 64'(tick_count), 64'd0);
    chk("arst_led", 64'(tick_led), 64'd0);
    chk("arst_state", 64'(state), 64'(S_RUN));
    chk("arst_queue_empty", 64'(q.size()), 64'd0);
    exp_cnt = '0;
    exp_led = 1'b0;

    // After release the default period is back; then reset while in BRK
    wait_to(118);
    rst = 1'b0;
    bp_en = 1'b1;
    pc = 32'h20;
    push_pulse(122);
    wait_to(123);
    pc = 32'h10;
    wait_to(126);
    chk("rst2_bp_state", 64'(state), 64'(S_BRK));
    chk("rst2_count", 64'(tick_count), 64'd1);
    wait_to(128);
    #2 rst = 1'b1;
    #1;
    chk("brk_rst_hit", 64'(bp_hit), 64'd0);
    chk("brk_rst_state", 64'(state), 64'(S_RUN));
    chk("brk_rst_count", 64'(tick_count), 64'd0);
    chk("brk_rst_queue_empty", 64'(q.size()), 64'd0);
    wait_to(130);
    rst = 1'b0;
    bp_en = 1'b0;
    wait_to(132);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
Run-control sequencer for the CPU core. It replaces the free-running divided clock with a single hwclk domain plus a one-cycle cpu_en strobe. It supports run, halt, single-step and a PC breakpoint, so the board can be debugged instruction by instruction. It sits between hwclk, the board buttons and LEDs, and the cpu/imem pair; the CPU advances only on cycles where cpu_en=1.

Parameters:
CNT_W, 32, width of tick timer and period register
PERIOD_DEFAULT, 1000000, reset value of period register; one tick every period+1 hwclk cycles
ADDR_W, 32, width of pc and bp_addr
START_RUN, 1, reset state: 1=RUN, 0=HALT

Ports:
hwclk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
run_req  in  1  one-cycle pulse, request free-run
halt_req  in  1  one-cycle pulse, request halt
step_req  in  1  one-cycle pulse, request exactly one CPU tick
period_load  in  1  load period_in into period register
period_in  in  CNT_W  new period value
bp_en  in  1  breakpoint enable
bp_addr  in  ADDR_W  breakpoint fetch address
pc  in  ADDR_W  CPU fetch address (imem_addr), stable between ticks
cpu_en  out  1  one-hwclk-cycle CPU advance strobe (registered)
tick_led  out  1  toggles on every cpu_en; drives led1
state  out  2  0=HALT, 1=RUN, 2=STEP, 3=BRK
bp_hit  out  1  high while in BRK
tick_count  out  32  number of cpu_en pulses issued; wraps

Behaviour:
- Reset values: state=RUN if START_RUN else HALT; cntr=0; period_reg=PERIOD_DEFAULT; cpu_en=0; tick_led=0; bp_hit=0; tick_count=0; skip_bp=0.
- Timer counts only in RUN and STEP. Each cycle cntr+1. "Expiry" is cntr==period_reg; on expiry cntr<=0.
- At expiry a tick fires: cpu_en=1 on the next cycle, for exactly one cycle. First tick arrives period_reg+1 cycles after timer start, then every period_reg+1 cycles. period_reg=0 gives cpu_en every cycle.
- On each tick, tick_led toggles and tick_count increments, both in the same cycle cpu_en rises.
- In HALT and BRK, cntr is held at 0 and cpu_en=0.
- Request priority when several are high together: halt_req > step_req > run_req.
- HALT: step_req -> STEP; run_req -> RUN.
- RUN:
  - halt_req -> HALT, cntr<=0, and any expiry that same cycle is suppressed.
  - step_req and run_req are ignored.
  - At expiry with bp_en=1, pc==bp_addr and skip_bp=0: tick suppressed, go to BRK, bp_hit=1.
  - Otherwise the tick fires and skip_bp<=0.
- STEP:
  - The first expiry fires a tick, then -> HALT. The breakpoint is not checked in STEP.
  - halt_req before expiry -> HALT with no tick.
  - run_req -> RUN, counter kept.
  - step_req is ignored.
- BRK:
  - step_req -> STEP and bp_hit<=0; the step executes the breakpointed instruction.
  - run_req -> RUN, bp_hit<=0, skip_bp<=1, so the first RUN tick ignores the breakpoint.
  - halt_req -> HALT, bp_hit<=0.
- period_load: allowed in any state. period_reg<=period_in and cntr<=0 in the same cycle. An expiry in that cycle is suppressed.
- Arithmetic: cntr and tick_count wrap modulo 2^width, with no saturation. The compare is exact equality.
- Reset asserted mid-operation forces all reset values immediately, including dropping cpu_en asynchronously. No request is remembered across reset.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the state encoding (HALT=0, RUN=1, STEP=2, BRK=3);
  - PERIOD_DEFAULT;
  - CNT_W.
- One sub-module, tick_timer:
  - contains the counter, period register, load and compare;
  - inputs: enable, clear, load;
  - output: expire.
- The FSM, breakpoint compare, strobe register and statistics stay in cpu_step_ctrl.

Test Plan:
- PERIOD_DEFAULT=3, START_RUN=1, release rst -> cpu_en pulses every 4 cycles, first 4 cycles after release; tick_led toggles on each; tick_count=5 after 5 pulses.
- RUN, halt_req on an expiry cycle -> no cpu_en, state=HALT, cntr=0. Then step_req -> exactly one cpu_en 4 cycles later, then state=HALT.
- RUN, bp_en=1, bp_addr=0x10, pc=0x10 at expiry -> no pulse, state=BRK, bp_hit=1. run_req -> next expiry fires despite pc=0x10. With pc still 0x10 at the following expiry -> BRK again.
- Same cycle halt_req=step_req=run_req=1 in HALT -> state stays HALT. Then step_req=run_req=1 in HALT -> STEP.
- period_load with period_in=0 in RUN -> cpu_en high every cycle from 2 cycles after load. period_load with period_in=7 -> pulses every 8 cycles.
- Assert rst while cpu_en=1 and state=BRK -> cpu_en=0, bp_hit=0 and tick_count=0 immediately. After release, state=RUN and period=PERIOD_DEFAULT.
